dcache_direct_mapped: RTL and testbench
=======================================

Name: dcache_direct_mapped

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage and a block-wide backing data memory.
- Hits complete in the same cycle, combinationally, so the pipeline never stalls on a hit.
- Misses stall the MEM stage while a multi-cycle FSM writes back a dirty victim and refills the line over a valid/ready backend interface.
- Replaces the direct single-cycle data-memory connection in the pipelined CPU.

Parameters:
- NUM_SETS, 16, number of lines; power of 2, at least 2.
- BLOCK_WORDS, 4, 32-bit words per line; fixed at 4, so the line is 128 bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; asserted at 0.
- is_input_valid  in  1  CPU request present this cycle.
- addr  in  32  byte address; bits [1:0] ignored.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- din  in  32  store data.
- is_ready  out  1  cache is in IDLE and can evaluate a request.
- is_output_valid  out  1  request completed this cycle.
- is_hit  out  1  tag match on a valid line this cycle.
- dout  out  32  load data; 0 unless is_output_valid and mem_read.
- mem_req_valid  out  1  backend request outstanding.
- mem_req_write  out  1  1 = block write, 0 = block read.
- mem_req_addr  out  32  block-aligned byte address; low 4 bits = 0.
- mem_req_data  out  128  victim line for writes.
- mem_req_ready  in  1  backend accepts the request this cycle.
- mem_resp_valid  in  1  one-cycle pulse; read data valid.
- mem_resp_data  in  128  refill line.
- hit_count  out  32  completed hits since reset.
- miss_count  out  32  misses since reset, counted once per miss.

Behaviour:
- Address split:
  - offset = addr[3:2]
  - index = addr[4 +: log2(NUM_SETS)]
  - tag = remaining upper bits (24 bits at the defaults)
- Per-line state: valid, dirty, tag, 128-bit data.
- Reset (async, active-low):
  - all valid and dirty bits cleared; FSM to IDLE; counters to 0.
  - mem_req_valid = 0, is_output_valid = 0, is_hit = 0, dout = 0; is_ready = 1 once reset deasserts.
  - Reset during an outstanding backend transaction abandons it. The backend must tolerate an abandoned request.
- FSM states: IDLE, WB_REQ, ALLOC_REQ, ALLOC_WAIT.
- IDLE:
  - is_ready = 1.
  - A request (is_input_valid and (mem_read or mem_write)) is evaluated combinationally.
  - Hit: is_hit = 1 and is_output_valid = 1 in the same cycle; load drives dout = selected word. A store writes the word and sets dirty at posedge. hit_count increments.
  - Miss: is_hit = 0, is_output_valid = 0, miss_count increments. Next state is WB_REQ if the victim is valid and dirty, else ALLOC_REQ.
- WB_REQ:
  - mem_req_valid = 1, mem_req_write = 1.
  - mem_req_addr = {victim tag, index, 4'b0}; mem_req_data = victim line.
  - On mem_req_ready: clear dirty, go to ALLOC_REQ.
- ALLOC_REQ:
  - mem_req_valid = 1, mem_req_write = 0, mem_req_addr = {addr[31:4], 4'b0}.
  - On mem_req_ready: go to ALLOC_WAIT.
- ALLOC_WAIT:
  - On mem_resp_valid: install line, set valid = 1, dirty = 0, tag = request tag; go to IDLE.
  - The stalled request re-evaluates as a hit in IDLE on the next cycle and counts as a hit too. Miss latency is therefore a minimum of 3 cycles clean and 4 cycles dirty, plus backend wait.
- Request stability: the requester holds is_input_valid, addr, din, mem_read and mem_write stable from the miss until is_output_valid. Behaviour is undefined if they change.
- mem_req_valid is held, with stable address and data, until mem_req_ready. mem_resp_valid outside ALLOC_WAIT is ignored.
- mem_read and mem_write both 1: treated as a store; dout = 0.
- is_input_valid with neither mem_read nor mem_write: no lookup and no counter change; is_output_valid = 0.
- is_ready = 0 in every non-IDLE state.
- Counters wrap at 2^32.

Decomposition:
- Shared package dcache_pkg holds:
  - FSM state encoding (IDLE = 0, WB_REQ = 1, ALLOC_REQ = 2, ALLOC_WAIT = 3)
  - BLOCK_BYTES = 16 and OFFSET_BITS = 4
  - helper localparams for index and tag widths
- One sub-module: dcache_line_array, holding the tag/valid/dirty/data storage. It has async read, a single write port, and an async active-low clear of valid and dirty.

Test Plan:
- Cold load addr 0x0000_0040 with a backend responding 2 cycles after accept, line = {0x4,0x3,0x2,0x1} -> ALLOC_REQ emitted with mem_req_addr 0x40. Then one hit cycle with dout = 0x1; miss_count = 1, hit_count = 1.
- Store 0xDEAD_BEEF to 0x44 after a refill, then load 0x44 -> both complete same-cycle with is_hit = 1; dout = 0xDEAD_BEEF; no backend activity.
- Dirty eviction: store to 0x44, then load 0x144 (same index, tag 0x1) -> WB_REQ with mem_req_addr 0x40 and word1 = 0xDEAD_BEEF, then ALLOC_REQ with addr 0x140.
- Backend stall: hold mem_req_ready = 0 for 5 cycles -> mem_req_valid, address and data stay stable; is_ready stays 0.
- Reset asserted (reset = 0) in ALLOC_WAIT -> outputs drop immediately. After release, load 0x40 misses again and miss_count restarts from 1.
- Stray mem_resp_valid pulse while in IDLE -> no state or data change.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and geometry for the direct-mapped data cache
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WB_REQ     = 2'd1,
        ALLOC_REQ  = 2'd2,
        ALLOC_WAIT = 2'd3
    } dcache_state_e;

    localparam int BLOCK_BYTES = 16;
    localparam int OFFSET_BITS = 4;
    localparam int WORD_BITS   = 32;
    localparam int LINE_BITS   = 128;
    localparam int ADDR_BITS   = 32;

    function automatic int index_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int num_sets);
        return ADDR_BITS - OFFSET_BITS - $clog2(num_sets);
    endfunction

endpackage

// File: rtl/dcache_direct_mapped_if.sv
// rtl/dcache_direct_mapped_if.sv - CPU request bus and block-wide backend bus of the data cache
interface dcache_direct_mapped_if;
    import dcache_pkg::*;

    logic                   is_input_valid;
    logic [ADDR_BITS-1:0]   addr;
    logic                   mem_read;
    logic                   mem_write;
    logic [WORD_BITS-1:0]   din;
    logic                   is_ready;
    logic                   is_output_valid;
    logic                   is_hit;
    logic [WORD_BITS-1:0]   dout;

    logic                   mem_req_valid;
    logic                   mem_req_write;
    logic [ADDR_BITS-1:0]   mem_req_addr;
    logic [LINE_BITS-1:0]   mem_req_data;
    logic                   mem_req_ready;
    logic                   mem_resp_valid;
    logic [LINE_BITS-1:0]   mem_resp_data;

    // master is the environment (pipeline + backing memory), slave is the cache
    modport master (
        output is_input_valid, addr, mem_read, mem_write, din,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  is_ready, is_output_valid, is_hit, dout,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_data
    );

    modport slave (
        input  is_input_valid, addr, mem_read, mem_write, din,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output is_ready, is_output_valid, is_hit, dout,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data
    );

endinterface

// File: rtl/dcache_line_array.sv
// rtl/dcache_line_array.sv - tag/valid/dirty/data storage, async read, one full-line write port
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int NUM_SETS   = 16,
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [LINE_BITS-1:0]  rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic                  wr_valid,
    input  logic                  wr_dirty,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [LINE_BITS-1:0]  wr_data
);

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [NUM_SETS];
    logic [LINE_BITS-1:0] data_q [NUM_SETS];

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

    // Only the status bits are cleared; stale tags/data are masked by valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= wr_valid;
            dirty_q[wr_index] <= wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_direct_mapped.sv
// rtl/dcache_direct_mapped.sv - direct-mapped write-back write-allocate data cache with miss FSM
module dcache_direct_mapped
    import dcache_pkg::*;
#(
    parameter int NUM_SETS    = 16,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    dcache_direct_mapped_if.slave   bus,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);

    localparam int INDEX_BITS = index_bits(NUM_SETS);
    localparam int TAG_BITS   = tag_bits(NUM_SETS);

    if (BLOCK_WORDS != 4) begin : g_bad_block_words
        $error("dcache_direct_mapped: BLOCK_WORDS must be 4");
    end
    if (NUM_SETS < 2 || (NUM_SETS & (NUM_SETS - 1)) != 0) begin : g_bad_num_sets
        $error("dcache_direct_mapped: NUM_SETS must be a power of 2, at least 2");
    end

    dcache_state_e state_q, state_d;

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  unused_addr_bits;

    assign offset           = bus.addr[3:2];
    assign index            = bus.addr[OFFSET_BITS +: INDEX_BITS];
    assign tag              = bus.addr[ADDR_BITS-1 -: TAG_BITS];
    assign unused_addr_bits = ^bus.addr[1:0];

    logic                 rd_valid, rd_dirty;
    logic [TAG_BITS-1:0]  rd_tag;
    logic [LINE_BITS-1:0] rd_data;
    logic                 wr_en, wr_valid, wr_dirty;
    logic [TAG_BITS-1:0]  wr_tag;
    logic [LINE_BITS-1:0] wr_data;

    dcache_line_array #(
        .NUM_SETS   (NUM_SETS),
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_lines (
        .clk      (clk),
        .reset    (reset),
        .rd_index (index),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (index),
        .wr_valid (wr_valid),
        .wr_dirty (wr_dirty),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data)
    );

    logic                 req;
    logic                 hit;
    logic [WORD_BITS-1:0] sel_word;
    logic [LINE_BITS-1:0] merged_line;
    logic                 hit_inc, miss_inc;

    assign req      = bus.is_input_valid && (bus.mem_read || bus.mem_write);
    assign hit      = rd_valid && (rd_tag == tag);
    assign sel_word = rd_data[{offset, 5'd0} +: WORD_BITS];

    always_comb begin
        merged_line = rd_data;
        merged_line[{offset, 5'd0} +: WORD_BITS] = bus.din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        bus.is_ready        = 1'b0;
        bus.is_output_valid = 1'b0;
        bus.is_hit          = 1'b0;
        bus.dout            = '0;
        bus.mem_req_valid   = 1'b0;
        bus.mem_req_write   = 1'b0;
        bus.mem_req_addr    = '0;
        bus.mem_req_data    = '0;
        wr_en               = 1'b0;
        wr_valid            = rd_valid;
        wr_dirty            = rd_dirty;
        wr_tag              = rd_tag;
        wr_data             = rd_data;
        hit_inc             = 1'b0;
        miss_inc            = 1'b0;

        case (state_q)
            IDLE: begin
                bus.is_ready = 1'b1;
                if (req) begin
                    if (hit) begin
                        bus.is_hit          = 1'b1;
                        bus.is_output_valid = 1'b1;
                        hit_inc             = 1'b1;
                        // A request with both read and write set behaves as a store
                        if (bus.mem_write) begin
                            wr_en    = 1'b1;
                            wr_dirty = 1'b1;
                            wr_data  = merged_line;
                        end else begin
                            bus.dout = sel_word;
                        end
                    end else begin
                        miss_inc = 1'b1;
                        state_d  = (rd_valid && rd_dirty) ? WB_REQ : ALLOC_REQ;
                    end
                end
            end
            WB_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_write = 1'b1;
                bus.mem_req_addr  = {rd_tag, index, 4'b0};
                bus.mem_req_data  = rd_data;
                if (bus.mem_req_ready) begin
                    wr_en    = 1'b1;
                    wr_dirty = 1'b0;
                    state_d  = ALLOC_REQ;
                end
            end
            ALLOC_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {bus.addr[ADDR_BITS-1:OFFSET_BITS], 4'b0};
                if (bus.mem_req_ready) begin
                    state_d = ALLOC_WAIT;
                end
            end
            ALLOC_WAIT: begin
                if (bus.mem_resp_valid) begin
                    wr_en    = 1'b1;
                    wr_valid = 1'b1;
                    wr_dirty = 1'b0;
                    wr_tag   = tag;
                    wr_data  = bus.mem_resp_data;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc) hit_count <= hit_count + 32'd1;
            if (miss_inc) miss_count <= miss_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// tb/tb_dcache_direct_mapped.sv - directed vector bench for dcache_direct_mapped
module tb_dcache_direct_mapped;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] hit_count, miss_count;

    dcache_direct_mapped_if bus();

    dcache_direct_mapped #(.NUM_SETS(16), .BLOCK_WORDS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic         w;
        logic [31:0]  a;
        logic [127:0] d;
    } breq_t;

    breq_t        log_q[$];
    logic [127:0] model [logic [31:0]];
    int           stall_cfg = 0;
    int           stall_neg = 0;
    int           unstable = 0;
    int           ready_busy = 0;
    bit           stray_pulse = 0;

    function automatic logic [127:0] line_of(input logic [31:0] blk);
        logic [127:0] l;
        if (model.exists(blk)) return model[blk];
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = 32'hA000_0000 ^ blk ^ w;
        return l;
    endfunction

    // Backing memory: accepts after stall_cfg cycles, answers reads 2 cycles after accept
    initial begin : backend
        breq_t        held;
        bit           in_req = 0;
        int           wait_left = 0;
        int           resp_cnt = 0;
        logic [31:0]  resp_blk = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            if (!reset) begin
                in_req   = 0;
                resp_cnt = 0;
            end else begin
                if (stray_pulse) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = {4{32'hFFFF_FFFF}};
                    stray_pulse = 0;
                end
                if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        bus.mem_resp_valid = 1'b1;
                        bus.mem_resp_data  = line_of(resp_blk);
                    end
                end
                if (bus.mem_req_valid) begin
                    if (bus.is_ready) ready_busy++;
                    if (!in_req) begin
                        in_req    = 1;
                        wait_left = stall_cfg;
                        held      = '{bus.mem_req_write, bus.mem_req_addr, bus.mem_req_data};
                    end else if (held.w !== bus.mem_req_write || held.a !== bus.mem_req_addr ||
                                 held.d !== bus.mem_req_data) begin
                        unstable++;
                    end
                    if (wait_left == 0) begin
                        bus.mem_req_ready = 1'b1;
                        in_req = 0;
                        log_q.push_back(held);
                        if (held.w) model[held.a] = held.d;
                        else begin
                            resp_blk = held.a;
                            resp_cnt = 2;
                        end
                    end else begin
                        wait_left--;
                        stall_neg++;
                    end
                end
            end
        end
    end

    task automatic cpu_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                           output logic hitc, output logic [31:0] dv, output int cyc);
        bus.is_input_valid = 1'b1;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.addr      = a;
        bus.din       = d;
        cyc = 0; hitc = 1'b0; dv = '0;
        forever begin
            @(negedge clk);
            if (bus.is_output_valid) begin
                hitc = bus.is_hit;
                dv   = bus.dout;
                break;
            end
            cyc++;
            if (cyc > 200) begin
                total++; bad++;
                $display("FAIL req_timeout addr=%0h got=no completion exp=completion", a);
                break;
            end
        end
        @(posedge clk); #1;
        bus.is_input_valid = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic        exp_miss;
        logic        exp_wb;
        logic [31:0] exp_wb_addr;
        logic [31:0] exp_wb_w1;
        logic [31:0] exp_dout;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[12];

    initial begin : main
        logic        hc;
        logic [31:0] dv;
        int          cyc;
        int          nreq;

        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 32'h0,  32'h0,         32'h0000_0001, 4};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_004C, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,         32'h0000_0004, 0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0,  32'h0, 0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,         32'hDEAD_BEEF, 0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0144, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'hA000_0141, 5};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0048, 32'h0, 1'b1, 1'b0, 32'h0,  32'h0,         32'h0000_0003, 4};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,         32'hDEAD_BEEF, 0};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_0050, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 32'h0,  32'h0, 4};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0050, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,         32'h1234_5678, 0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_1050, 32'h0, 1'b1, 1'b1, 32'h50, 32'hA000_0051, 32'hA000_1050, 5};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0, 1'b1, 1'b0, 32'h0,  32'h0,         32'hA000_00F3, 4};
        vecs[11] = '{1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 1'b1, 1'b0, 32'h0,  32'h0,         32'h5FFF_FFF0, 4};

        model[32'h40] = {32'h4, 32'h3, 32'h2, 32'h1};
        bus.is_input_valid = 1'b0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.addr = '0; bus.din = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", bus.mem_req_valid, 1'b0);
        check("rst_out_valid", bus.is_output_valid, 1'b0);
        check("rst_dout", bus.dout, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_is_ready", bus.is_ready, 1'b1);
        check("rst_is_hit", bus.is_hit, 1'b0);
        check("rst_hit_count", hit_count, 32'h0);
        check("rst_miss_count", miss_count, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            log_q.delete();
            cpu_req(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, hc, dv, cyc);
            check($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
            check($sformatf("v%0d_is_hit", i), hc, 1'b1);
            check($sformatf("v%0d_dout", i), dv, vecs[i].exp_dout);
            nreq = vecs[i].exp_miss ? (vecs[i].exp_wb ? 2 : 1) : 0;
            check($sformatf("v%0d_backend_reqs", i), log_q.size(), nreq);
            if (log_q.size() == nreq && nreq > 0) begin
                if (vecs[i].exp_wb) begin
                    check($sformatf("v%0d_wb_write", i), log_q[0].w, 1'b1);
                    check($sformatf("v%0d_wb_addr", i), log_q[0].a, vecs[i].exp_wb_addr);
                    check($sformatf("v%0d_wb_word1", i), log_q[0].d[63:32], vecs[i].exp_wb_w1);
                end
                check($sformatf("v%0d_alloc_write", i), log_q[nreq-1].w, 1'b0);
                check($sformatf("v%0d_alloc_addr", i), log_q[nreq-1].a, {vecs[i].a[31:4], 4'h0});
            end
        end
        check("tbl_hit_count", hit_count, 32'd12);
        check("tbl_miss_count", miss_count, 32'd7);

        // Valid without read or write: no lookup, no counting
        bus.is_input_valid = 1'b1; bus.addr = 32'h40;
        @(negedge clk);
        check("noop_out_valid", bus.is_output_valid, 1'b0);
        check("noop_is_hit", bus.is_hit, 1'b0);
        @(posedge clk); #1;
        bus.is_input_valid = 1'b0;
        check("noop_hit_count", hit_count, 32'd12);
        check("noop_miss_count", miss_count, 32'd7);

        // Backend stall of 5 cycles on both write-back and allocate
        cpu_req(1'b0, 1'b1, 32'h44, 32'hCAFE_0001, hc, dv, cyc);
        check("st_hit_cycles", cyc, 0);
        log_q.delete();
        stall_cfg = 5; stall_neg = 0; unstable = 0; ready_busy = 0;
        cpu_req(1'b1, 1'b0, 32'h244, 32'h0, hc, dv, cyc);
        stall_cfg = 0;
        check("stall_cycles", cyc, 15);
        check("stall_dout", dv, 32'hA000_0241);
        check("stall_neg", stall_neg, 10);
        check("stall_unstable", unstable, 0);
        check("stall_ready_busy", ready_busy, 0);
        check("stall_reqs", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("stall_wb_addr", log_q[0].a, 32'h40);
            check("stall_wb_word1", log_q[0].d[63:32], 32'hCAFE_0001);
        end

        // Reset while waiting for refill data
        log_q.delete();
        bus.is_input_valid = 1'b1; bus.mem_read = 1'b1; bus.addr = 32'h340;
        for (int i = 0; i < 50 && log_q.size() == 0; i++) @(negedge clk);
        check("rw_alloc_seen", log_q.size(), 1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rw_req_valid", bus.mem_req_valid, 1'b0);
        check("rw_out_valid", bus.is_output_valid, 1'b0);
        check("rw_is_hit", bus.is_hit, 1'b0);
        check("rw_dout", bus.dout, 32'h0);
        check("rw_miss_count", miss_count, 32'h0);
        bus.is_input_valid = 1'b0; bus.mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        log_q.delete();
        cpu_req(1'b1, 1'b0, 32'h40, 32'h0, hc, dv, cyc);
        check("rr_cycles", cyc, 4);
        check("rr_dout", dv, 32'h1);
        check("rr_miss_count", miss_count, 32'd1);
        check("rr_hit_count", hit_count, 32'd1);

        // Stray response while idle must be ignored
        stray_pulse = 1;
        repeat (3) @(posedge clk);
        #1;
        log_q.delete();
        cpu_req(1'b1, 1'b0, 32'h40, 32'h0, hc, dv, cyc);
        check("stray_cycles", cyc, 0);
        check("stray_dout", dv, 32'h1);
        check("stray_reqs", log_q.size(), 0);
        check("stray_hit_count", hit_count, 32'd2);
        check("stray_miss_count", miss_count, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
